shift_ser_ctrl: RTL

- Parametrised controller and deserialiser for a daisy-chain of 74LV165-style parallel-in/serial-out shift registers.
- Per capture: pulses SH/LD low to load the chain, generates a divided, glitch-free serial clock, samples the serial data line once per bit (MSB first) and presents the assembled word with a one-cycle valid strobe.
- Sits between the board-level input expanders and the register/logic fabric.
- Adds over the fixed 8-bit version: configurable width, serclk divider, start/busy handshake, parallel data capture and a free-running mode.

---
 rtl/shift_ser_ctrl.sv | 108 ++++++++++
 1 files changed

// File: rtl/shift_ser_ctrl.sv
// Controller and deserialiser for a daisy chain of 74LV165-style PISO shift registers.
// Loads the chain, clocks it with a divided serclk and assembles the word MSB first.
module shift_ser_ctrl #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DIV        = 1,
  parameter bit          CONTINUOUS = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_ser,
  output logic             o_shld,
  output logic             o_serclk,
  output logic             o_busy,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid
);

  localparam int unsigned PW = $clog2(DIV + 1);
  localparam int unsigned BW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SETUP = 3'd2,
    S_LOW   = 3'd3,
    S_HIGH  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [PW-1:0]    phase;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] sreg;

  logic phase_last;
  logic bit_last;
  logic timed_state;
  logic shld_nxt;
  logic serclk_nxt;
  logic busy_nxt;
  logic valid_nxt;

  assign phase_last  = (phase == PW'(DIV - 1));
  assign bit_last    = (bit_cnt == BW'(WIDTH - 1));
  assign timed_state = (state == S_LOAD) || (state == S_SETUP) ||
                       (state == S_LOW)  || (state == S_HIGH);

  // State, counters, shift register and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      phase    <= '0;
      bit_cnt  <= '0;
      sreg     <= '0;
      o_shld   <= 1'b1;
      o_serclk <= 1'b1;
      o_busy   <= 1'b0;
      o_valid  <= 1'b0;
      o_data   <= '0;
    end else begin
      state <= state_nxt;

      if (timed_state && !phase_last) phase <= phase + PW'(1);
      else                            phase <= '0;

      if (state == S_LOAD)                    bit_cnt <= '0;
      else if (state == S_HIGH && phase_last) bit_cnt <= bit_cnt + BW'(1);

      // Sample at the end of the low phase, just before the chain's rising edge
      if (state == S_LOW && phase_last) sreg <= WIDTH'({sreg, i_ser});

      o_shld   <= shld_nxt;
      o_serclk <= serclk_nxt;
      o_busy   <= busy_nxt;
      o_valid  <= valid_nxt;
      if (valid_nxt) o_data <= sreg;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (i_start || CONTINUOUS) state_nxt = S_LOAD;
      S_LOAD:  if (phase_last) state_nxt = S_SETUP;
      S_SETUP: if (phase_last) state_nxt = S_LOW;
      S_LOW:   if (phase_last) state_nxt = S_HIGH;
      S_HIGH:  if (phase_last) state_nxt = bit_last ? S_DONE : S_LOW;
      S_DONE:  state_nxt = CONTINUOUS ? S_LOAD : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state so the flops track the state register
  always_comb begin
    shld_nxt   = 1'b1;
    serclk_nxt = 1'b1;
    busy_nxt   = 1'b0;
    valid_nxt  = 1'b0;
    if (state_nxt == S_LOAD) shld_nxt   = 1'b0;
    if (state_nxt == S_LOW)  serclk_nxt = 1'b0;
    if (state_nxt != S_IDLE) busy_nxt   = 1'b1;
    if (state_nxt == S_DONE) valid_nxt  = 1'b1;
  end

endmodule
